// File: rtl/cpu_pkg.sv
// Shared CPU definitions for the fetch sequencer: opcodes, stack micro-op selects and FSM states.
package cpu_pkg;

    localparam logic [4:0] OP_NOP     = 5'd0;
    localparam logic [4:0] OP_PUSH    = 5'd8;
    localparam logic [4:0] OP_POP     = 5'd9;
    localparam logic [4:0] OP_LDD     = 5'd10;
    localparam logic [4:0] OP_POP_INJ = 5'd11;
    localparam logic [4:0] OP_CALL    = 5'd20;
    localparam logic [4:0] OP_RET     = 5'd21;
    localparam logic [4:0] OP_RTI     = 5'd22;

    localparam logic [1:0] PUSH_NONE  = 2'd0;
    localparam logic [1:0] PUSH_PC_HI = 2'd1;
    localparam logic [1:0] PUSH_PC_LO = 2'd2;
    localparam logic [1:0] PUSH_FLAGS = 2'd3;

    typedef enum logic [3:0] {
        IDLE,
        INT_HI,
        INT_LO,
        INT_JMP,
        CALL_HI,
        CALL_LO,
        CALL_JMP,
        RTI_FLG,
        POP_HI,
        POP_LO,
        CAP_HI,
        CAP_LO,
        HAZ
    } seq_state_e;

    // Builds a micro-op word carrying only the opcode field; register fields are left zero.
    function automatic logic [15:0] micro_op(input logic [4:0] op);
        return {op, 11'd0};
    endfunction

endpackage

// File: rtl/load_use_detect.sv
// Load-use hazard comparator between the last issued word and the word now being fetched.
module load_use_detect
    import cpu_pkg::*;
(
    input  logic [4:0] last_op,
    input  logic [2:0] last_src,
    input  logic [2:0] last_dst,
    input  logic [2:0] cur_src,
    input  logic [2:0] cur_dst,
    output logic       hazard
);

    // LDD writes its dst field, POP writes its src field; reading that register next cycle needs a bubble.
    always_comb begin
        hazard = 1'b0;
        if (last_op == OP_LDD) begin
            hazard = (last_dst == cur_src) || (last_dst == cur_dst);
        end else if (last_op == OP_POP) begin
            hazard = (last_src == cur_src) || (last_src == cur_dst);
        end
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch-stage sequencer: injects stack micro-ops for interrupts, CALL, RET and RTI,
// and inserts a single bubble on load-use hazards.
module fetch_sequencer
    import cpu_pkg::*;
#(
    parameter int              PC_W     = 32,
    parameter logic [PC_W-1:0] RESET_PC = PC_W'(32'h0000_001F)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load_enable,
    input  logic            fetch_valid,
    input  logic [15:0]     instr,
    input  logic            interrupt,
    input  logic [PC_W-1:0] pc_in,
    input  logic [15:0]     call_target,
    input  logic [15:0]     pop_data,
    output logic            stall,
    output logic            inject_valid,
    output logic [15:0]     inject_instr,
    output logic [1:0]      push_sel,
    output logic [15:0]     push_data,
    output logic            pc_load,
    output logic [PC_W-1:0] pc_load_value,
    output logic            busy
);

    seq_state_e      state_q, state_d;
    logic            int_pending_q, int_pending_d;
    logic            int_prev_q, int_prev_d;
    logic [PC_W-1:0] pc_latch_q, pc_latch_d;
    logic [15:0]     hi_latch_q, hi_latch_d;
    logic [10:0]     last_q, last_d;

    logic            int_edge;
    logic            hazard;
    logic            issue_valid;
    logic [15:0]     issue_word;
    logic [31:0]     pc_ext;
    logic [4:0]      cur_op;
    logic            unused_instr_bits;

    assign int_edge          = interrupt & ~int_prev_q;
    assign pc_ext            = 32'(pc_latch_q);
    assign cur_op            = instr[15:11];
    assign unused_instr_bits = ^instr[4:0];

    load_use_detect u_load_use_detect (
        .last_op  (last_q[10:6]),
        .last_src (last_q[5:3]),
        .last_dst (last_q[2:0]),
        .cur_src  (instr[10:8]),
        .cur_dst  (instr[7:5]),
        .hazard   (hazard)
    );

    // State and latch registers; reset aborts any sequence in flight without finishing it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            int_pending_q <= 1'b0;
            int_prev_q    <= 1'b0;
            pc_latch_q    <= '0;
            hi_latch_q    <= '0;
            last_q        <= '0;
        end else begin
            state_q       <= state_d;
            int_pending_q <= int_pending_d;
            int_prev_q    <= int_prev_d;
            pc_latch_q    <= pc_latch_d;
            hi_latch_q    <= hi_latch_d;
            last_q        <= last_d;
        end
    end

    // Next-state and output decode; a new interrupt edge is remembered until IDLE can service it.
    always_comb begin
        state_d       = state_q;
        int_pending_d = int_pending_q | int_edge;
        int_prev_d    = interrupt;
        pc_latch_d    = pc_latch_q;
        hi_latch_d    = hi_latch_q;
        issue_valid   = 1'b0;
        issue_word    = '0;
        stall         = 1'b0;
        inject_valid  = 1'b0;
        inject_instr  = '0;
        push_sel      = PUSH_NONE;
        push_data     = '0;
        pc_load       = 1'b0;
        pc_load_value = '0;
        busy          = (state_q != IDLE);

        if (load_enable) begin
            state_d = IDLE;
            busy    = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (int_pending_q || int_edge) begin
                        state_d       = INT_HI;
                        int_pending_d = 1'b0;
                        pc_latch_d    = pc_in;
                        stall         = fetch_valid;
                    end else if (fetch_valid && cur_op == OP_CALL) begin
                        state_d    = CALL_HI;
                        pc_latch_d = pc_in;
                        stall      = 1'b1;
                    end else if (fetch_valid && cur_op == OP_RTI) begin
                        state_d = RTI_FLG;
                        stall   = 1'b1;
                    end else if (fetch_valid && cur_op == OP_RET) begin
                        state_d = POP_HI;
                        stall   = 1'b1;
                    end else if (fetch_valid && hazard) begin
                        state_d = HAZ;
                        stall   = 1'b1;
                    end else if (fetch_valid) begin
                        issue_valid = 1'b1;
                        issue_word  = instr;
                    end
                end
                INT_HI, CALL_HI: begin
                    state_d      = (state_q == INT_HI) ? INT_LO : CALL_LO;
                    stall        = 1'b1;
                    inject_valid = 1'b1;
                    inject_instr = micro_op(OP_PUSH);
                    push_sel     = PUSH_PC_HI;
                    push_data    = pc_ext[31:16];
                end
                INT_LO, CALL_LO: begin
                    state_d      = (state_q == INT_LO) ? INT_JMP : CALL_JMP;
                    stall        = 1'b1;
                    inject_valid = 1'b1;
                    inject_instr = micro_op(OP_PUSH);
                    push_sel     = PUSH_PC_LO;
                    push_data    = pc_ext[15:0];
                end
                INT_JMP: begin
                    state_d       = IDLE;
                    stall         = 1'b1;
                    pc_load       = 1'b1;
                    pc_load_value = '0;
                end
                CALL_JMP: begin
                    state_d       = IDLE;
                    stall         = 1'b1;
                    pc_load       = 1'b1;
                    pc_load_value = PC_W'(call_target);
                end
                RTI_FLG: begin
                    state_d      = POP_HI;
                    stall        = 1'b1;
                    inject_valid = 1'b1;
                    inject_instr = micro_op(OP_POP_INJ);
                    push_sel     = PUSH_FLAGS;
                end
                POP_HI, POP_LO: begin
                    state_d      = (state_q == POP_HI) ? POP_LO : CAP_HI;
                    stall        = 1'b1;
                    inject_valid = 1'b1;
                    inject_instr = micro_op(OP_POP_INJ);
                end
                CAP_HI: begin
                    state_d    = CAP_LO;
                    stall      = 1'b1;
                    hi_latch_d = pop_data;
                end
                CAP_LO: begin
                    state_d       = IDLE;
                    stall         = 1'b1;
                    pc_load       = 1'b1;
                    pc_load_value = PC_W'({hi_latch_q, pop_data});
                end
                HAZ: begin
                    state_d      = IDLE;
                    stall        = 1'b1;
                    inject_valid = 1'b1;
                    inject_instr = micro_op(OP_NOP);
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        if (inject_valid) begin
            issue_valid = 1'b1;
            issue_word  = inject_instr;
        end

        if (load_enable) begin
            last_d = '0;
        end else if (issue_valid) begin
            last_d = issue_word[15:5];
        end else begin
            last_d = last_q;
        end

        if (rst) begin
            stall         = 1'b0;
            inject_valid  = 1'b0;
            inject_instr  = '0;
            push_sel      = PUSH_NONE;
            push_data     = '0;
            busy          = 1'b0;
            pc_load       = 1'b1;
            pc_load_value = RESET_PC;
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: stimulus queues expected non-idle cycles, a monitor checks them.
module tb_fetch_sequencer;

    localparam int PC_W = 32;

    typedef struct packed {
        logic        stall;
        logic        busy;
        logic        inject_valid;
        logic [15:0] inject_instr;
        logic [1:0]  push_sel;
        logic [15:0] push_data;
        logic        pc_load;
        logic [31:0] pc_load_value;
    } ev_t;

    typedef struct packed {
        logic [15:0] first;
        logic [15:0] second;
        logic        bubble;
    } hz_t;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            load_enable = 1'b0;
    logic            fetch_valid = 1'b0;
    logic [15:0]     instr = '0;
    logic            interrupt = 1'b0;
    logic [PC_W-1:0] pc_in = '0;
    logic [15:0]     call_target = '0;
    logic [15:0]     pop_data = '0;
    logic            stall;
    logic            inject_valid;
    logic [15:0]     inject_instr;
    logic [1:0]      push_sel;
    logic [15:0]     push_data;
    logic            pc_load;
    logic [PC_W-1:0] pc_load_value;
    logic            busy;

    ev_t expq[$];
    int  passCount  = 0;
    int  checkCount = 0;
    int  eventIndex = 0;
    hz_t hzTab [5];

    fetch_sequencer #(.PC_W(PC_W), .RESET_PC(32'h0000_001F)) dut (
        .clk           (clk),
        .rst           (rst),
        .load_enable   (load_enable),
        .fetch_valid   (fetch_valid),
        .instr         (instr),
        .interrupt     (interrupt),
        .pc_in         (pc_in),
        .call_target   (call_target),
        .pop_data      (pop_data),
        .stall         (stall),
        .inject_valid  (inject_valid),
        .inject_instr  (inject_instr),
        .push_sel      (push_sel),
        .push_data     (push_data),
        .pc_load       (pc_load),
        .pc_load_value (pc_load_value),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] mkInstr(input logic [4:0] op, input logic [2:0] src, input logic [2:0] dst);
        return {op, src, dst, 5'd0};
    endfunction

    function automatic ev_t mkEv(input logic st, input logic bz, input logic iv, input logic [15:0] ii,
                                 input logic [1:0] ps, input logic [15:0] pd, input logic pl, input logic [31:0] plv);
        return {st, bz, iv, ii, ps, pd, pl, plv};
    endfunction

    function automatic ev_t evStall();
        return mkEv(1'b1, 1'b0, 1'b0, 16'h0000, 2'd0, 16'h0000, 1'b0, 32'h0);
    endfunction

    function automatic ev_t evPushHi(input logic [31:0] pc);
        return mkEv(1'b1, 1'b1, 1'b1, 16'h4000, 2'd1, pc[31:16], 1'b0, 32'h0);
    endfunction

    function automatic ev_t evPushLo(input logic [31:0] pc);
        return mkEv(1'b1, 1'b1, 1'b1, 16'h4000, 2'd2, pc[15:0], 1'b0, 32'h0);
    endfunction

    function automatic ev_t evJmp(input logic [31:0] target);
        return mkEv(1'b1, 1'b1, 1'b0, 16'h0000, 2'd0, 16'h0000, 1'b1, target);
    endfunction

    function automatic ev_t evFlags();
        return mkEv(1'b1, 1'b1, 1'b1, 16'h5800, 2'd3, 16'h0000, 1'b0, 32'h0);
    endfunction

    function automatic ev_t evPop();
        return mkEv(1'b1, 1'b1, 1'b1, 16'h5800, 2'd0, 16'h0000, 1'b0, 32'h0);
    endfunction

    function automatic ev_t evCapHi();
        return mkEv(1'b1, 1'b1, 1'b0, 16'h0000, 2'd0, 16'h0000, 1'b0, 32'h0);
    endfunction

    function automatic ev_t evBubble();
        return mkEv(1'b1, 1'b1, 1'b1, 16'h0000, 2'd0, 16'h0000, 1'b0, 32'h0);
    endfunction

    // Drives one cycle of inputs just after a rising edge and waits for the next one.
    task automatic applyStimulus(input logic fv, input logic [15:0] ins, input logic intr, input logic [31:0] pc,
                                 input logic [15:0] ct, input logic [15:0] pd, input logic le);
        fetch_valid = fv;
        instr       = ins;
        interrupt   = intr;
        pc_in       = pc;
        call_target = ct;
        pop_data    = pd;
        load_enable = le;
        @(posedge clk);
        #1;
    endtask

    task automatic quiet(input int n);
        for (int i = 0; i < n; i++) begin
            applyStimulus(1'b0, 16'h0000, 1'b0, 32'h0, 16'h0, 16'h0, 1'b0);
        end
    endtask

    // Direct comparison of the whole output bundle, used where the monitor is blind (reset).
    task automatic checkOutput(input string name, input ev_t exp);
        ev_t act;
        #1;
        act = {stall, busy, inject_valid, inject_instr, push_sel, push_data, pc_load, pc_load_value};
        checkCount++;
        if (act === exp) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Every non-idle output cycle outside reset must match the next queued expectation.
    always @(negedge clk) begin
        ev_t act;
        ev_t exp;
        if (!rst && (stall || busy || inject_valid || pc_load || push_sel != 2'd0)) begin
            act = {stall, busy, inject_valid, inject_instr, push_sel, push_data, pc_load, pc_load_value};
            checkCount++;
            if (expq.size() == 0) begin
                $display("[TB] FAIL unexpected event %0d: got %h expected none", eventIndex, act);
            end else begin
                exp = expq.pop_front();
                if (act === exp) begin
                    passCount++;
                end else begin
                    $display("[TB] FAIL event %0d: got %h expected %h", eventIndex, act, exp);
                end
            end
            eventIndex++;
        end
    end

    initial begin
        hzTab[0] = {mkInstr(5'd10, 3'd0, 3'd3), mkInstr(5'd1, 3'd3, 3'd0), 1'b1};
        hzTab[1] = {mkInstr(5'd10, 3'd0, 3'd3), mkInstr(5'd1, 3'd4, 3'd0), 1'b0};
        hzTab[2] = {mkInstr(5'd10, 3'd1, 3'd5), mkInstr(5'd1, 3'd0, 3'd5), 1'b1};
        hzTab[3] = {mkInstr(5'd9,  3'd2, 3'd6), mkInstr(5'd1, 3'd0, 3'd2), 1'b1};
        hzTab[4] = {mkInstr(5'd9,  3'd2, 3'd6), mkInstr(5'd1, 3'd6, 3'd0), 1'b0};

        $display("[TB] reset");
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset outputs", mkEv(1'b0, 1'b0, 1'b0, 16'h0, 2'd0, 16'h0, 1'b1, 32'h0000_001F));
        rst = 1'b0;
        quiet(2);
        checkOutput("idle after reset", mkEv(1'b0, 1'b0, 1'b0, 16'h0, 2'd0, 16'h0, 1'b0, 32'h0));

        $display("[TB] interrupt in idle");
        expq.push_back(evStall());
        expq.push_back(evPushHi(32'h0000_0042));
        expq.push_back(evPushLo(32'h0000_0042));
        expq.push_back(evJmp(32'h0));
        applyStimulus(1'b1, 16'h0000, 1'b1, 32'h0000_0042, 16'h0, 16'h0, 1'b0);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 16'h0, 1'b0, 32'h0000_0099, 16'h0, 16'h0, 1'b0);
        quiet(2);

        $display("[TB] call");
        expq.push_back(evStall());
        expq.push_back(evPushHi(32'h0001_1234));
        expq.push_back(evPushLo(32'h0001_1234));
        expq.push_back(evJmp(32'h0000_0100));
        applyStimulus(1'b1, mkInstr(5'd20, 3'd0, 3'd0), 1'b0, 32'h0001_1234, 16'h0100, 16'h0, 1'b0);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 16'h0, 1'b0, 32'hBEEF_0000, 16'h0100, 16'h0, 1'b0);
        quiet(2);

        $display("[TB] rti");
        expq.push_back(evStall());
        expq.push_back(evFlags());
        expq.push_back(evPop());
        expq.push_back(evPop());
        expq.push_back(evCapHi());
        expq.push_back(evJmp(32'h0000_0050));
        applyStimulus(1'b1, mkInstr(5'd22, 3'd0, 3'd0), 1'b0, 32'h0, 16'h0, 16'hEEEE, 1'b0);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 16'h0, 1'b0, 32'h0, 16'h0, 16'hEEEE, 1'b0);
        applyStimulus(1'b0, 16'h0, 1'b0, 32'h0, 16'h0, 16'h0000, 1'b0);
        applyStimulus(1'b0, 16'h0, 1'b0, 32'h0, 16'h0, 16'h0050, 1'b0);
        quiet(2);

        $display("[TB] ret");
        expq.push_back(evStall());
        expq.push_back(evPop());
        expq.push_back(evPop());
        expq.push_back(evCapHi());
        expq.push_back(evJmp(32'h1234_5678));
        applyStimulus(1'b1, mkInstr(5'd21, 3'd0, 3'd0), 1'b0, 32'h0, 16'h0, 16'hEEEE, 1'b0);
        for (int i = 0; i < 2; i++) applyStimulus(1'b0, 16'h0, 1'b0, 32'h0, 16'h0, 16'hEEEE, 1'b0);
        applyStimulus(1'b0, 16'h0, 1'b0, 32'h0, 16'h0, 16'h1234, 1'b0);
        applyStimulus(1'b0, 16'h0, 1'b0, 32'h0, 16'h0, 16'h5678, 1'b0);
        quiet(2);

        $display("[TB] load-use hazards");
        for (int i = 0; i < 5; i++) begin
            if (hzTab[i].bubble) begin
                expq.push_back(evStall());
                expq.push_back(evBubble());
            end
            applyStimulus(1'b1, hzTab[i].first, 1'b0, 32'h0, 16'h0, 16'h0, 1'b0);
            applyStimulus(1'b1, hzTab[i].second, 1'b0, 32'h0, 16'h0, 16'h0, 1'b0);
            if (hzTab[i].bubble) begin
                applyStimulus(1'b1, hzTab[i].second, 1'b0, 32'h0, 16'h0, 16'h0, 1'b0);
                applyStimulus(1'b1, hzTab[i].second, 1'b0, 32'h0, 16'h0, 16'h0, 1'b0);
            end
            quiet(1);
        end
        quiet(1);

        $display("[TB] interrupt during ret");
        expq.push_back(evStall());
        expq.push_back(evPop());
        expq.push_back(evPop());
        expq.push_back(evCapHi());
        expq.push_back(evJmp(32'h0000_0077));
        expq.push_back(evPushHi(32'h0003_0077));
        expq.push_back(evPushLo(32'h0003_0077));
        expq.push_back(evJmp(32'h0));
        applyStimulus(1'b1, mkInstr(5'd21, 3'd0, 3'd0), 1'b0, 32'h0, 16'h0, 16'hEEEE, 1'b0);
        applyStimulus(1'b0, 16'h0, 1'b0, 32'h0, 16'h0, 16'hEEEE, 1'b0);
        applyStimulus(1'b0, 16'h0, 1'b1, 32'h0, 16'h0, 16'hEEEE, 1'b0);
        applyStimulus(1'b0, 16'h0, 1'b0, 32'h0, 16'h0, 16'h0000, 1'b0);
        applyStimulus(1'b0, 16'h0, 1'b0, 32'h0, 16'h0, 16'h0077, 1'b0);
        applyStimulus(1'b0, 16'h0, 1'b0, 32'h0003_0077, 16'h0, 16'h0, 1'b0);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 16'h0, 1'b0, 32'hAAAA_5555, 16'h0, 16'h0, 1'b0);
        quiet(3);

        $display("[TB] load_enable abort");
        expq.push_back(evStall());
        expq.push_back(evPushHi(32'h0005_0500));
        expq.push_back(evPushHi(32'h0000_0600));
        expq.push_back(evPushLo(32'h0000_0600));
        expq.push_back(evJmp(32'h0));
        applyStimulus(1'b1, mkInstr(5'd20, 3'd0, 3'd0), 1'b0, 32'h0005_0500, 16'h0200, 16'h0, 1'b0);
        applyStimulus(1'b0, 16'h0, 1'b0, 32'h0, 16'h0200, 16'h0, 1'b0);
        applyStimulus(1'b0, 16'h0, 1'b0, 32'h0, 16'h0200, 16'h0, 1'b1);
        applyStimulus(1'b1, mkInstr(5'd20, 3'd0, 3'd0), 1'b1, 32'h0, 16'h0200, 16'h0, 1'b1);
        applyStimulus(1'b0, 16'h0, 1'b0, 32'h0000_0600, 16'h0, 16'h0, 1'b0);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 16'h0, 1'b0, 32'h0, 16'h0, 16'h0, 1'b0);
        quiet(2);

        $display("[TB] reset during call");
        expq.push_back(evStall());
        expq.push_back(evPushHi(32'h0007_2345));
        applyStimulus(1'b1, mkInstr(5'd20, 3'd0, 3'd0), 1'b0, 32'h0007_2345, 16'h0300, 16'h0, 1'b0);
        applyStimulus(1'b0, 16'h0, 1'b0, 32'h0, 16'h0300, 16'h0, 1'b0);
        rst = 1'b1;
        checkOutput("reset mid call", mkEv(1'b0, 1'b0, 1'b0, 16'h0, 2'd0, 16'h0, 1'b1, 32'h0000_001F));
        quiet(2);
        rst = 1'b0;
        checkOutput("idle after mid-call reset", mkEv(1'b0, 1'b0, 1'b0, 16'h0, 2'd0, 16'h0, 1'b0, 32'h0));
        applyStimulus(1'b0, 16'h0, 1'b0, 32'h0, 16'h0300, 16'h0, 1'b0);
        quiet(4);

        checkCount++;
        if (expq.size() == 0) begin
            passCount++;
        end else begin
            $display("[TB] FAIL drain: got %0d events outstanding expected 0", expq.size());
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
